// File: rtl/exu_muldiv.sv
// exu_muldiv: iterative multiply/divide unit for the execute stage.
// The shift-add multiplier is always built. The restoring divider is built only when
// EXU_MULDIV_DIV_EN is defined; without it, divide/remainder ops complete as illegal.
module exu_muldiv (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [3:0]  in_op,
  input  logic [63:0] in_src1,
  input  logic [63:0] in_src2,
  input  logic        flush,
  output logic        stall_req,
  output logic        busy,
  output logic        out_valid,
  output logic [63:0] out_result,
  output logic        out_illegal
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  localparam logic [3:0] OpMul    = 4'd0;
  localparam logic [3:0] OpMulh   = 4'd1;
  localparam logic [3:0] OpMulhsu = 4'd2;
  localparam logic [3:0] OpDiv    = 4'd4;
  localparam logic [3:0] OpDivu   = 4'd5;
  localparam logic [3:0] OpRem    = 4'd6;
  localparam logic [3:0] OpRemu   = 4'd7;
  localparam logic [3:0] OpMulw   = 4'd8;
  localparam logic [3:0] OpDivw   = 4'd9;
  localparam logic [3:0] OpDivuw  = 4'd10;
  localparam logic [3:0] OpRemw   = 4'd11;
  localparam logic [3:0] OpRemuw  = 4'd12;

  function automatic logic op_is_w(input logic [3:0] op);
    return op inside {OpMulw, OpDivw, OpDivuw, OpRemw, OpRemuw};
  endfunction

  function automatic logic op_is_div(input logic [3:0] op);
    return op inside {OpDiv, OpDivu, OpRem, OpRemu, OpDivw, OpDivuw, OpRemw, OpRemuw};
  endfunction

  state_e        state_q, state_d;
  logic [5:0]    cnt_q, cnt_d;
  logic [3:0]    op_q, op_d;
  logic          neg_q, neg_d;
  // acc: product high half / partial remainder; lo: multiplier+product low / quotient
  logic [63:0]   acc_q, acc_d;
  logic [63:0]   lo_q, lo_d;
  logic [63:0]   opd_q, opd_d;
  logic [63:0]   out_result_q, out_result_d;
  logic          out_illegal_q, out_illegal_d;

  logic          a_sgn, b_sgn, in_w, in_legal, a_neg, b_neg;
  logic [63:0]   a_w, b_w, a_mag, b_mag;
  logic [64:0]   mul_sum;
  logic [63:0]   step_acc, step_lo, fin_res;
  logic [127:0]  prod, prod_s;
  logic [5:0]    cnt_last;

  // Operand decode: signedness per op, W ops use only bits 31:0.
  always_comb begin
    a_sgn = 1'b0;
    b_sgn = 1'b0;
    case (in_op)
      OpMul, OpMulh, OpDiv, OpRem, OpDivw, OpRemw: begin
        a_sgn = 1'b1;
        b_sgn = 1'b1;
      end
      OpMulhsu: a_sgn = 1'b1;
      default: ;
    endcase
    in_w  = op_is_w(in_op);
    a_w   = in_w ? {{32{a_sgn & in_src1[31]}}, in_src1[31:0]} : in_src1;
    b_w   = in_w ? {{32{b_sgn & in_src2[31]}}, in_src2[31:0]} : in_src2;
    a_neg = a_sgn & a_w[63];
    b_neg = b_sgn & b_w[63];
    a_mag = a_neg ? -a_w : a_w;
    b_mag = b_neg ? -b_w : b_w;
`ifdef EXU_MULDIV_DIV_EN
    in_legal = (in_op <= OpRemuw);
`else
    in_legal = (in_op <= OpRemuw) && !op_is_div(in_op);
`endif
  end

`ifdef EXU_MULDIV_DIV_EN
  function automatic logic op_is_rem(input logic [3:0] op);
    return op inside {OpRem, OpRemu, OpRemw, OpRemuw};
  endfunction

  logic        in_div, in_rem, div_zero, div_ovf, rem_ge;
  logic [63:0] a_sx, min_w, rem_sub, dval, dval_s;
  logic [64:0] rem_sh;

  // Divider corner cases resolved at accept time without iterating.
  always_comb begin
    in_div   = op_is_div(in_op);
    in_rem   = op_is_rem(in_op);
    a_sx     = in_w ? {{32{in_src1[31]}}, in_src1[31:0]} : in_src1;
    min_w    = in_w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
    div_zero = (b_w == '0);
    div_ovf  = a_sgn && (a_w == min_w) && (b_w == '1);
  end
`endif

  // One iteration of the active algorithm.
  always_comb begin
    mul_sum  = {1'b0, acc_q} + {1'b0, (lo_q[0] ? opd_q : 64'd0)};
    step_acc = mul_sum[64:1];
    step_lo  = {mul_sum[0], lo_q[63:1]};
`ifdef EXU_MULDIV_DIV_EN
    rem_sh  = {acc_q, lo_q[63]};
    rem_ge  = (rem_sh >= {1'b0, opd_q});
    rem_sub = rem_sh[63:0] - opd_q;
    if (op_is_div(op_q)) begin
      step_acc = rem_ge ? rem_sub : rem_sh[63:0];
      step_lo  = {lo_q[62:0], rem_ge};
    end
`endif
  end

  // Final result from the last iteration's values, with sign fix-up.
  always_comb begin
    cnt_last = op_is_w(op_q) ? 6'd31 : 6'd63;
    prod     = {step_acc, step_lo};
    prod_s   = neg_q ? -prod : prod;
    if (op_q == OpMulw) begin
      // 32 right shifts leave the low product word in lo[63:32]
      fin_res = {{32{step_lo[63]}}, step_lo[63:32]};
    end else if (op_q == OpMul) begin
      fin_res = prod_s[63:0];
    end else begin
      fin_res = prod_s[127:64];
    end
`ifdef EXU_MULDIV_DIV_EN
    dval   = op_is_rem(op_q) ? step_acc : step_lo;
    dval_s = neg_q ? -dval : dval;
    if (op_is_div(op_q)) begin
      fin_res = op_is_w(op_q) ? {{32{dval_s[31]}}, dval_s[31:0]} : dval_s;
    end
`endif
  end

  // Control FSM and datapath next state.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    op_d          = op_q;
    neg_d         = neg_q;
    acc_d         = acc_q;
    lo_d          = lo_q;
    opd_d         = opd_q;
    out_result_d  = out_result_q;
    out_illegal_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          op_d    = in_op;
          cnt_d   = '0;
          neg_d   = a_neg ^ b_neg;
          acc_d   = '0;
          opd_d   = a_mag;
          lo_d    = b_mag;
          state_d = StBusy;
          if (!in_legal) begin
            state_d       = StDone;
            out_result_d  = '0;
            out_illegal_d = 1'b1;
          end
`ifdef EXU_MULDIV_DIV_EN
          else if (in_div) begin
            opd_d = b_mag;
            // W dividend sits in the top word so its MSB shifts out first
            lo_d  = in_w ? {a_mag[31:0], 32'd0} : a_mag;
            if (in_rem) neg_d = a_neg;
            if (div_zero) begin
              state_d      = StDone;
              out_result_d = in_rem ? a_sx : '1;
            end else if (div_ovf) begin
              state_d      = StDone;
              out_result_d = in_rem ? '0 : a_w;
            end
          end
`endif
        end
      end
      StBusy: begin
        acc_d = step_acc;
        lo_d  = step_lo;
        if (cnt_q == cnt_last) begin
          state_d      = StDone;
          out_result_d = fin_res;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (flush) begin
      state_d       = StIdle;
      out_illegal_d = 1'b0;
    end
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      op_q          <= '0;
      neg_q         <= 1'b0;
      acc_q         <= '0;
      lo_q          <= '0;
      opd_q         <= '0;
      out_result_q  <= '0;
      out_illegal_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      op_q          <= op_d;
      neg_q         <= neg_d;
      acc_q         <= acc_d;
      lo_q          <= lo_d;
      opd_q         <= opd_d;
      out_result_q  <= out_result_d;
      out_illegal_q <= out_illegal_d;
    end
  end

  assign stall_req   = ((state_q == StIdle) && in_valid && !flush) || (state_q == StBusy);
  assign busy        = (state_q == StBusy);
  assign out_valid   = (state_q == StDone);
  assign out_result  = out_result_q;
  assign out_illegal = out_illegal_q;

endmodule

// File: tb/tb_exu_muldiv.sv
// Directed, table-driven bench for exu_muldiv plus flush/reset sequences.
`timescale 1ns/1ps
module tb_exu_muldiv;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [3:0]  in_op;
  logic [63:0] in_src1;
  logic [63:0] in_src2;
  logic        flush;
  logic        stall_req;
  logic        busy;
  logic        out_valid;
  logic [63:0] out_result;
  logic        out_illegal;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef EXU_MULDIV_DIV_EN
  localparam bit DivEn = 1'b1;
`else
  localparam bit DivEn = 1'b0;
`endif

  typedef struct {
    logic [3:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    int          lat;
    logic [63:0] res;
    logic        ill;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  exu_muldiv dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_op      (in_op),
    .in_src1    (in_src1),
    .in_src2    (in_src2),
    .flush      (flush),
    .stall_req  (stall_req),
    .busy       (busy),
    .out_valid  (out_valid),
    .out_result (out_result),
    .out_illegal(out_illegal)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                              input int lat, input logic [63:0] res, input logic ill);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.lat = lat; v.res = res; v.ill = ill;
    // Without the divider every divide/remainder op completes as illegal.
    if (!DivEn && (op inside {4, 5, 6, 7, 9, 10, 11, 12})) begin
      v.lat = 1; v.res = '0; v.ill = 1'b1;
    end
    return v;
  endfunction

  // Apply one op, hold garbage inputs while it runs, check timing and result.
  task automatic run_vec(input int idx, input vec_t v);
    int          lat      = 0;
    logic        stall_ok = 1'b1;
    logic        st_done  = 1'b1;
    logic        ill      = 1'b0;
    logic [63:0] res      = '0;
    @(negedge clk);
    in_valid = 1'b1; in_op = v.op; in_src1 = v.a; in_src2 = v.b;
    #1;
    if (stall_req !== 1'b1) stall_ok = 1'b0;
    @(posedge clk);
    #1;
    in_op = 4'hF; in_src1 = {$urandom, $urandom}; in_src2 = {$urandom, $urandom};
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        lat = k; res = out_result; ill = out_illegal; st_done = stall_req;
        break;
      end
      if (stall_req !== 1'b1 || busy !== 1'b1) stall_ok = 1'b0;
    end
    in_valid = 1'b0;
    chk($sformatf("v%0d_latency", idx), 64'(lat), 64'(v.lat));
    chk($sformatf("v%0d_result", idx), res, v.res);
    chk($sformatf("v%0d_illegal", idx), {63'd0, ill}, {63'd0, v.ill});
    chk($sformatf("v%0d_stall_busy", idx), {63'd0, stall_ok}, 64'd1);
    chk($sformatf("v%0d_stall_done", idx), {63'd0, st_done}, 64'd0);
    @(negedge clk);
    chk($sformatf("v%0d_strobe_drop", idx), {60'd0, out_valid, out_illegal, busy, stall_req},
        64'd0);
  endtask

  initial begin
    logic seen;
    rst = 1'b1; in_valid = 1'b0; in_op = '0; in_src1 = '0; in_src2 = '0; flush = 1'b0;

    //           op     A                       B                       lat res                     ill
    vecs.push_back(mk(4'd0,  64'd3,                  64'd5,                  65, 64'd15,                 0));
    vecs.push_back(mk(4'd0,  -64'sd3,                64'd5,                  65, 64'hFFFFFFFFFFFFFFF1,   0));
    vecs.push_back(mk(4'd1,  64'h8000000000000000,   64'd2,                  65, 64'hFFFFFFFFFFFFFFFF,   0));
    vecs.push_back(mk(4'd2,  64'hFFFFFFFFFFFFFFFF,   64'hFFFFFFFFFFFFFFFF,   65, 64'hFFFFFFFFFFFFFFFF,   0));
    vecs.push_back(mk(4'd3,  64'hFFFFFFFFFFFFFFFF,   64'hFFFFFFFFFFFFFFFF,   65, 64'hFFFFFFFFFFFFFFFE,   0));
    vecs.push_back(mk(4'd3,  64'h0000000100000000,   64'h0000000100000000,   65, 64'd1,                  0));
    vecs.push_back(mk(4'd8,  64'h7FFFFFFF,           64'd2,                  33, 64'hFFFFFFFFFFFFFFFE,   0));
    vecs.push_back(mk(4'd8,  64'hDEADBEEF00000003,   64'h1234567800000004,   33, 64'hC,                  0));
    vecs.push_back(mk(4'd13, 64'd9,                  64'd9,                  1,  64'd0,                  1));
    vecs.push_back(mk(4'd15, 64'hFFFF,               64'h1234,               1,  64'd0,                  1));
    vecs.push_back(mk(4'd4,  -64'sd7,                64'd2,                  65, 64'hFFFFFFFFFFFFFFFD,   0));
    vecs.push_back(mk(4'd6,  -64'sd7,                64'd2,                  65, 64'hFFFFFFFFFFFFFFFF,   0));
    vecs.push_back(mk(4'd5,  64'd42,                 64'd0,                  1,  64'hFFFFFFFFFFFFFFFF,   0));
    vecs.push_back(mk(4'd7,  64'd42,                 64'd0,                  1,  64'd42,                 0));
    vecs.push_back(mk(4'd4,  64'h8000000000000000,   64'hFFFFFFFFFFFFFFFF,   1,  64'h8000000000000000,   0));
    vecs.push_back(mk(4'd6,  64'h8000000000000000,   64'hFFFFFFFFFFFFFFFF,   1,  64'd0,                  0));
    vecs.push_back(mk(4'd5,  64'd100,                64'd7,                  65, 64'd14,                 0));
    vecs.push_back(mk(4'd7,  64'd100,                64'd7,                  65, 64'd2,                  0));
    vecs.push_back(mk(4'd5,  64'hFFFFFFFFFFFFFFFF,   64'h10,                 65, 64'h0FFFFFFFFFFFFFFF,   0));
    vecs.push_back(mk(4'd9,  64'hFFFFFFFFFFFFFFF9,   64'd2,                  33, 64'hFFFFFFFFFFFFFFFD,   0));
    vecs.push_back(mk(4'd11, 64'hFFFFFFFFFFFFFFF9,   64'd2,                  33, 64'hFFFFFFFFFFFFFFFF,   0));
    vecs.push_back(mk(4'd10, 64'h12345678FFFFFFFF,   64'd2,                  33, 64'h7FFFFFFF,           0));
    vecs.push_back(mk(4'd12, 64'd100,                64'd7,                  33, 64'd2,                  0));
    vecs.push_back(mk(4'd9,  64'd5,                  64'hFFFFFFFF00000000,   1,  64'hFFFFFFFFFFFFFFFF,   0));
    vecs.push_back(mk(4'd12, 64'h0000000180000005,   64'd0,                  1,  64'hFFFFFFFF80000005,   0));
    vecs.push_back(mk(4'd9,  64'h80000000,           64'hFFFFFFFF,           1,  64'hFFFFFFFF80000000,   0));
    vecs.push_back(mk(4'd11, 64'h80000000,           64'hFFFFFFFF,           1,  64'd0,                  0));

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_illegal", {63'd0, out_illegal}, 64'd0);
    chk("reset_result", out_result, 64'd0);
    chk("reset_stall", {63'd0, stall_req}, 64'd0);

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // Flush during BUSY at T+10
    @(negedge clk);
    in_valid = 1'b1; in_op = 4'd0; in_src1 = 64'd3; in_src2 = 64'd5;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("flush_busy_before", {63'd0, busy}, 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy_after", {63'd0, busy}, 64'd0);
    seen = out_valid;
    repeat (80) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen = 1'b1;
    end
    chk("flush_no_valid", {63'd0, seen}, 64'd0);
    run_vec(100, vecs[0]);

    // Flush together with in_valid in IDLE accepts nothing
    @(negedge clk);
    in_valid = 1'b1; in_op = 4'd13; flush = 1'b1;
    #1 chk("flush_idle_stall", {63'd0, stall_req}, 64'd0);
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    seen = out_valid | busy;
    repeat (5) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen = 1'b1;
    end
    chk("flush_idle_nothing", {63'd0, seen}, 64'd0);

    // Asynchronous reset pulse at T+5
    @(negedge clk);
    in_valid = 1'b1; in_op = 4'd0; in_src1 = 64'd7; in_src2 = 64'd9;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_busy_before", {63'd0, busy}, 64'd1);
    rst = 1'b1;
    #1;
    chk("rst_async_busy", {63'd0, busy}, 64'd0);
    chk("rst_async_result", out_result, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (80) begin
      @(negedge clk);
      if (out_valid === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    chk("rst_no_valid", {63'd0, seen}, 64'd0);
    run_vec(101, vecs[6]);
    run_vec(102, vecs[1]);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/exu_muldiv.md
EXU_MULDIV -- requirements
Module: exu_muldiv

Interface
REQ-001 SHALL have port clk  input  1  clock, all state on rising edge.
REQ-002 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have port in_valid  input  1  op present from execute-stage register this cycle.
REQ-004 SHALL have port in_op  input  4  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU, 8 MULW, 9 DIVW, 10 DIVUW, 11 REMW, 12 REMUW, 13-15 reserved.
REQ-005 SHALL have port in_src1  input  64  operand A (rs1 data).
REQ-006 SHALL have port in_src2  input  64  operand B (rs2 data).
REQ-007 SHALL have port flush  input  1  abort any in-flight op.
REQ-008 SHALL have port stall_req  output  1  holds upstream pipeline registers while high.
REQ-009 SHALL have port busy  output  1  high in BUSY state.
REQ-010 SHALL have port out_valid  output  1  one-cycle result strobe.
REQ-011 SHALL have port out_result  output  64  result, valid only with out_valid.
REQ-012 SHALL have port out_illegal  output  1  one-cycle strobe with out_valid for an unsupported op.

Function
REQ-013 SHALL implement FSM IDLE, BUSY, DONE; out_valid = (state==DONE), busy = (state==BUSY).
REQ-014 SHALL accept an op only in IDLE with in_valid=1 and flush=0; accept cycle is T; operands and op are latched at the edge ending T.
REQ-015 SHALL drive stall_req = (IDLE & in_valid & ~flush) | BUSY; stall_req is low in DONE so the pipeline advances on the result cycle.
REQ-016 SHALL run 64 iterations (BUSY cycles T+1..T+64) for 64-bit ops and 32 iterations (T+1..T+32) for W ops; a 6-bit counter starts at 0, DONE is entered on the edge where counter == N-1.
REQ-017 SHALL assert out_valid in cycle T+65 (64-bit) or T+33 (W), then return to IDLE; a new op may be accepted in the DONE cycle only on the following cycle (IDLE).
REQ-018 SHALL multiply with a shift-add of operand magnitudes into a 128-bit product, negating the product when result sign requires; MUL returns bits 63:0; MULH/MULHSU/MULHU return bits 127:64.
REQ-019 SHALL divide with restoring division on magnitudes; quotient sign = sign(A) xor sign(B), remainder sign = sign(A) for signed ops.
REQ-020 SHALL, for W ops, use operand bits 31:0 (sign- or zero-extended per op) and sign-extend bit 31 of the 32-bit result to 64 bits.
REQ-021 SHALL bypass BUSY (IDLE->DONE, out_valid at T+1) for divide by zero: quotient all ones, remainder = dividend (W ops: sign-extended low 32 bits).
REQ-022 SHALL bypass BUSY for signed overflow (most-negative / -1): quotient = dividend, remainder = 0, at width of the op.
REQ-023 SHALL treat ops 13-15 as illegal: IDLE->DONE, out_valid and out_illegal at T+1, out_result = 0.
REQ-024 SHALL, when flush=1 in any state, go to IDLE on the next edge with no out_valid; flush with in_valid in IDLE accepts nothing.
REQ-025 SHALL ignore in_valid, in_op and in_src* while BUSY or DONE.

Reset
REQ-026 SHALL on rst force state IDLE, counter 0, all datapath registers 0, out_valid 0, out_illegal 0, out_result 0, busy 0, regardless of clock.
REQ-027 SHALL, when rst asserts mid-operation, discard the op with no out_valid after release.

Configuration
REQ-028 SHALL compile the divider only when macro EXU_MULDIV_DIV_EN is defined.
REQ-029 SHALL, with EXU_MULDIV_DIV_EN defined, support all ops 0-12 as above.
REQ-030 SHALL, without EXU_MULDIV_DIV_EN, treat ops 4-7 and 9-12 exactly as illegal ops (REQ-023); multiply ops unchanged.

Verification
REQ-031 SHALL cover: MUL A=3, B=5 accepted at T -> stall_req high T..T+64, out_valid at T+65, out_result=15.
REQ-032 SHALL cover: DIV A=-7, B=2 -> out_result 0xFFFFFFFFFFFFFFFD at T+65; REM same operands -> 0xFFFFFFFFFFFFFFFF.
REQ-033 SHALL cover: DIVU A=42, B=0 -> out_valid at T+1, out_result 0xFFFFFFFFFFFFFFFF; REMU -> 42.
REQ-034 SHALL cover: DIV A=0x8000000000000000, B=-1 -> out_result 0x8000000000000000 at T+1; REM -> 0.
REQ-035 SHALL cover: MULW A=0x7FFFFFFF, B=2 -> out_valid at T+33, out_result 0xFFFFFFFFFFFFFFFE.
REQ-036 SHALL cover: flush at T+10 during BUSY -> busy low at T+11, no out_valid; rst pulse at T+5 likewise; next op accepted cleanly.
